// File: rtl/pellet_tracker.sv
// pellet_tracker: tracks eaten pellets, BCD score and round count from Pac-Man's position and lives.
// Latency: a hit sampled at edge N updates eaten/eat_pulse/score in cycle N+1; all outputs are registered.
// Backpressure: none; runs every cycle. space=0 pauses consumes, and HOLD/OVER ignore hits.
// Ports: clk/rst (sync, active-low); h_pac/v_pac Pac-Man top-left; life lives left; space run enable;
//        eaten pellet mask; eat_pulse consume strobe; score 4-digit BCD; round boards cleared; game_over.
module pellet_tracker #(
  parameter int PEL_X0      = 147,
  parameter int PEL_X1      = 478,
  parameter int PEL_Y0      = 50,
  parameter int PEL_Y1      = 141,
  parameter int PEL_Y2      = 304,
  parameter int PEL_Y3      = 395,
  parameter int PAC_SIZE    = 20,
  parameter int PEL_SIZE    = 15,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_pac,
  input  logic [9:0]  v_pac,
  input  logic [1:0]  life,
  input  logic        space,
  output logic [7:0]  eaten,
  output logic        eat_pulse,
  output logic [15:0] score,
  output logic [3:0]  round,
  output logic        game_over
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  // 12-bit compare space: coordinate plus sprite size never wraps.
  localparam logic [11:0] PEL_YS [4] = '{12'(PEL_Y0), 12'(PEL_Y1), 12'(PEL_Y2), 12'(PEL_Y3)};

  logic [1:0]    state_q, state_d;
  logic [7:0]    eaten_q, eaten_d;
  logic          eat_pulse_q, eat_pulse_d;
  logic [15:0]   score_q, score_d;
  logic [3:0]    round_q, round_d;
  logic          game_over_q, game_over_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  logic [7:0]    hit;
  logic [7:0]    cand;
  logic [7:0]    pick;

  // Add 10 points; anything at 9990 or above pins to 9999.
  function automatic logic [15:0] bcd_add10(input logic [15:0] s);
    logic [3:0] th, hu, te;
    th = s[15:12];
    hu = s[11:8];
    te = s[7:4];
    if (s[15:4] == 12'h999) begin
      return 16'h9999;
    end
    if (te == 4'd9) begin
      te = 4'd0;
      if (hu == 4'd9) begin
        hu = 4'd0;
        th = th + 4'd1;
      end else begin
        hu = hu + 4'd1;
      end
    end else begin
      te = te + 4'd1;
    end
    return {th, hu, te, s[3:0]};
  endfunction

  // Bounding-box overlap for each pellet; bits 0-3 left column, 4-7 right column.
  always_comb begin
    logic [11:0] hx, vy, px, py;
    hx  = {2'b00, h_pac};
    vy  = {2'b00, v_pac};
    hit = 8'h00;
    for (int i = 0; i < 8; i++) begin
      px = (i < 4) ? 12'(PEL_X0) : 12'(PEL_X1);
      py = PEL_YS[i % 4];
      hit[i] = (hx + 12'(PAC_SIZE - 1) >= px) && (hx <= px + 12'(PEL_SIZE - 1)) &&
               (vy + 12'(PAC_SIZE - 1) >= py) && (vy <= py + 12'(PEL_SIZE - 1));
    end
  end

  // Only uneaten pellets count; isolate the lowest set bit so one pellet goes per cycle.
  assign cand = hit & ~eaten_q;
  assign pick = cand & (~cand + 8'd1);

  always_comb begin
    state_d     = state_q;
    eaten_d     = eaten_q;
    eat_pulse_d = 1'b0;
    score_d     = score_q;
    round_d     = round_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (space) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // Game over wins over a same-cycle consume.
        if (life == 2'd0) begin
          state_d = S_OVER;
        end else if (space && (pick != 8'h00)) begin
          eaten_d     = eaten_q | pick;
          eat_pulse_d = 1'b1;
          score_d     = bcd_add10(score_q);
          if ((eaten_q | pick) == 8'hFF) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      S_HOLD: begin
        // Counter value k is seen on the (k+1)th edge after entry, so the
        // full board stays visible for exactly HOLD_CYCLES cycles.
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_PLAY;
          eaten_d    = 8'h00;
          round_d    = round_q + 4'd1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_OVER;
      end
    endcase
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      eaten_q     <= 8'h00;
      eat_pulse_q <= 1'b0;
      score_q     <= 16'h0000;
      round_q     <= 4'd0;
      game_over_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      eaten_q     <= eaten_d;
      eat_pulse_q <= eat_pulse_d;
      score_q     <= score_d;
      round_q     <= round_d;
      game_over_q <= game_over_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign eaten     = eaten_q;
  assign eat_pulse = eat_pulse_q;
  assign score     = score_q;
  assign round     = round_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pellet_tracker.sv
// tb_pellet_tracker: scoreboarded bench for pellet_tracker with a short hold interval.
// Expected outputs are computed from a behavioural model when inputs are applied, then compared after the edge.
// No flow control on the DUT; every clock produces one compared vector.
module tb_pellet_tracker;

  localparam int HOLD  = 4;
  localparam int NEU_X = 476;
  localparam int NEU_Y = 364;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_pac, v_pac;
  logic [1:0]  life;
  logic        space;
  logic [7:0]  eaten;
  logic        eat_pulse;
  logic [15:0] score;
  logic [3:0]  round;
  logic        game_over;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  int         m_state = 0;   // 0 idle, 1 play, 2 hold, 3 over
  logic [7:0] m_eaten = 8'h00;
  bit         m_pulse = 1'b0;
  int         m_score = 0;
  logic [3:0] m_round = 4'd0;
  int         m_cnt   = 0;
  bit         m_go    = 1'b0;

  logic [29:0] sb [$];

  always #5 clk = ~clk;

  pellet_tracker #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .h_pac(h_pac), .v_pac(v_pac), .life(life), .space(space),
    .eaten(eaten), .eat_pulse(eat_pulse), .score(score), .round(round), .game_over(game_over)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int px_of(input int i);
    return (i < 4) ? 147 : 478;
  endfunction

  function automatic int py_of(input int i);
    case (i % 4)
      0:       return 50;
      1:       return 141;
      2:       return 304;
      default: return 395;
    endcase
  endfunction

  function automatic bit hit(input int h, input int v, input int px, input int py);
    return (h + 19 >= px) && (h <= px + 14) && (v + 19 >= py) && (v <= py + 14);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit done;
    m_pulse = 1'b0;
    if (!rst) begin
      m_state = 0; m_eaten = 8'h00; m_score = 0; m_round = 4'd0; m_cnt = 0; m_go = 1'b0;
    end else begin
      case (m_state)
        0: if (space) m_state = 1;
        1: begin
          if (life == 2'd0) begin
            m_state = 3;
            m_go    = 1'b1;
          end else if (space) begin
            done = 1'b0;
            for (int i = 0; i < 8; i++) begin
              if (!done && !m_eaten[i] && hit(int'(h_pac), int'(v_pac), px_of(i), py_of(i))) begin
                m_eaten[i] = 1'b1;
                m_pulse    = 1'b1;
                m_score    = (m_score + 10 > 9999) ? 9999 : m_score + 10;
                done       = 1'b1;
              end
            end
            if (m_eaten == 8'hFF) begin
              m_state = 2;
              m_cnt   = 0;
            end
          end
        end
        2: begin
          if (m_cnt + 1 == HOLD) begin
            m_state = 1;
            m_eaten = 8'h00;
            m_round = m_round + 4'd1;
            m_cnt   = 0;
          end else begin
            m_cnt++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: push the expected result, clock, then pop and compare.
  task automatic step();
    logic [29:0] exp;
    model_edge();
    sb.push_back({m_eaten, m_pulse, to_bcd(m_score), m_round, m_go});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check_eq("cycle", {2'b00, eaten, eat_pulse, score, round, game_over}, {2'b00, exp});
  endtask

  task automatic park();
    h_pac = 10'(NEU_X);
    v_pac = 10'(NEU_Y);
  endtask

  // Wait out any hold, then eat the lowest uneaten pellet.
  task automatic consume_next();
    int g;
    int idx;
    g = 0;
    park();
    while (m_eaten == 8'hFF && g < 3 * HOLD) begin
      step();
      g++;
    end
    idx = 0;
    for (int i = 7; i >= 0; i--) if (!m_eaten[i]) idx = i;
    h_pac = 10'(px_of(idx));
    v_pac = 10'(py_of(idx));
    step();
    park();
  endtask

  initial begin
    rst = 1'b0; space = 1'b0; life = 2'd3;
    park();
    #2;
    repeat (3) step();
    check_eq("rst_all", {2'b00, eaten, eat_pulse, score, round, game_over}, 32'h0);

    // Neutral position: no hits for 100 cycles.
    rst = 1'b1; space = 1'b1;
    repeat (100) step();
    check_eq("idle_eaten", {24'h0, eaten}, 32'h00);
    check_eq("idle_score", {16'h0, score}, 32'h0000);

    // First pellet.
    h_pac = 10'd147; v_pac = 10'd50;
    step();
    check_eq("p0_eaten", {24'h0, eaten}, 32'h01);
    check_eq("p0_pulse", {31'h0, eat_pulse}, 32'h1);
    check_eq("p0_score", {16'h0, score}, 32'h0010);
    step();
    check_eq("p0_no_repeat", {31'h0, eat_pulse}, 32'h0);

    // Remaining seven pellets, one per cycle.
    for (int i = 1; i < 8; i++) begin
      h_pac = 10'(px_of(i));
      v_pac = 10'(py_of(i));
      step();
    end
    park();
    check_eq("full_eaten", {24'h0, eaten}, 32'hFF);
    check_eq("full_score", {16'h0, score}, 32'h0080);
    repeat (HOLD - 1) step();
    check_eq("hold_last", {24'h0, eaten}, 32'hFF);
    step();
    check_eq("restart_eaten", {24'h0, eaten}, 32'h00);
    check_eq("restart_round", {28'h0, round}, 32'h1);

    // Paused while overlapping pellet 2.
    space = 1'b0;
    h_pac = 10'(px_of(2)); v_pac = 10'(py_of(2));
    repeat (3) step();
    check_eq("pause_eaten", {24'h0, eaten}, 32'h00);
    space = 1'b1;
    step();
    check_eq("resume_eaten", {24'h0, eaten}, 32'h04);
    check_eq("resume_pulse", {31'h0, eat_pulse}, 32'h1);
    park();

    // Build score up to 9990, then saturate.
    for (int k = 0; k < 1200 && m_score < 9990; k++) consume_next();
    check_eq("score_9990", {16'h0, score}, 32'h9990);
    consume_next();
    check_eq("sat_first", {16'h0, score}, 32'h9999);
    consume_next();
    check_eq("sat_again", {16'h0, score}, 32'h9999);
    check_eq("sat_pulse", {31'h0, eat_pulse}, 32'h1);

    // Game over on the same cycle as a pellet-5 hit.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    h_pac = 10'(px_of(5)); v_pac = 10'(py_of(5)); life = 2'd0;
    step();
    check_eq("over_eaten", {24'h0, eaten}, 32'h00);
    check_eq("over_flag", {31'h0, game_over}, 32'h1);
    check_eq("over_pulse", {31'h0, eat_pulse}, 32'h0);
    life = 2'd2;
    space = 1'b0; step();
    space = 1'b1; step();
    step();
    check_eq("over_sticky", {31'h0, game_over}, 32'h1);
    check_eq("over_frozen", {24'h0, eaten}, 32'h00);
    rst = 1'b0;
    step();
    check_eq("rst_again", {2'b00, eaten, eat_pulse, score, round, game_over}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
